// File: rtl/dmem_pkg.sv
// Shared types for the wait-state data memory: access size encoding,
// controller state encoding, and the address alignment helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Force the low address bits down to the natural alignment of the size.
    // Size 2'b11 is treated as a word.
    function automatic logic [1:0] align_lo(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: align_lo = lo;
            SZ_HALF: align_lo = {lo[1], 1'b0};
            default: align_lo = 2'b00;
        endcase
    endfunction

    // True when the low address bits do not match the natural alignment.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lo[0];
            default: is_misaligned = (lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: byte enables and replicated
// store data for writes, lane extraction plus sign/zero extension for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        unsigned_ld,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [31:0] rword_sh;

    // Bring the addressed lane down to bit 0 so loads only look at the low bits.
    assign rword_sh = rword >> {addr_lo, 3'b000};

    // Lane select, store replication and load extension by access size.
    always_comb begin
        be        = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rword;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = unsigned_ld ? {24'h0, rword_sh[7:0]}
                                        : {{24{rword_sh[7]}}, rword_sh[7:0]};
            end
            SZ_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = unsigned_ld ? {16'h0, rword_sh[15:0]}
                                        : {{16{rword_sh[15]}}, rword_sh[15:0]};
            end
            default: begin
                be        = 4'b1111;
                wdata_sh  = wdata;
                rdata_ext = rword;
            end
        endcase
    end

endmodule

// File: rtl/dmem_wait.sv
// Single-port data memory with a fixed number of wait states per access.
// One access in flight at a time: IDLE accepts, WAIT stalls, RESP completes.
// Optional macro DMEM_MISALIGN_CHK_EN: misaligned accesses complete with
// err = 1 and no effect; without it they are silently aligned down.
module dmem_wait
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e             state, state_nx;
    logic [3:0]         cnt, cnt_nx;
    logic               accept;

    logic               we_p0;
    logic [1:0]         size_p0;
    logic               uns_p0;
    logic [IDX_W+1:0]   addr_p0;
    logic [31:0]        wdata_p0;

    logic [31:0]        mem [DEPTH];
    logic [IDX_W-1:0]   idx;
    logic [1:0]         lo_eff;
    logic               mis;
    logic [3:0]         be;
    logic [31:0]        wdata_sh;
    logic [31:0]        rdata_ext;
    logic               store_commit;
    logic               unused_addr_hi;

    // Address bits above the array are ignored, so accesses wrap.
    assign unused_addr_hi = ^addr[31:IDX_W+2];

    assign accept = (state == IDLE) && req;
    assign idx    = addr_p0[IDX_W+1:2];

    // Control state register; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state: accept in IDLE, count wait states, single-cycle response.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nx   = 4'd0;
                    state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request capture at accept; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= we;
            size_p0  <= size;
            uns_p0   <= unsigned_ld;
            addr_p0  <= addr[IDX_W+1:0];
            wdata_p0 <= wdata;
        end
    end

`ifdef DMEM_MISALIGN_CHK_EN
    assign lo_eff = addr_p0[1:0];
    assign mis    = is_misaligned(size_p0, addr_p0[1:0]);
    assign err    = (state == RESP) && mis;
`else
    assign lo_eff = align_lo(size_p0, addr_p0[1:0]);
    assign mis    = 1'b0;
    assign err    = 1'b0;
`endif

    dmem_lane_align u_lane (
        .size        (size_p0),
        .addr_lo     (lo_eff),
        .unsigned_ld (uns_p0),
        .wdata       (wdata_p0),
        .rword       (mem[idx]),
        .be          (be),
        .wdata_sh    (wdata_sh),
        .rdata_ext   (rdata_ext)
    );

    assign store_commit = (state == RESP) && we_p0 && !mis && !reset;

    // Byte-lane write at the completion edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (store_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);
    assign rdata = (ready && !we_p0 && !mis) ? rdata_ext : 32'h0;

endmodule

// File: tb/tb_dmem_wait.sv
// Scoreboard bench for dmem_wait: each access pushes its expected response,
// an independent monitor pops and compares on every ready pulse.
module tb_dmem_wait;

    localparam int DEPTH       = 64;
    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        unsigned_ld = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    logic [32:0] exp_q[$];

    dmem_wait #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .size        (size),
        .unsigned_ld (unsigned_ld),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every response against the scoreboard, and require
    // quiet outputs whenever no response is presented.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready actual=1 required=0 rdata=0x%08h", rdata);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("resp_rdata", rdata, e[31:0]);
                chk("resp_err", {31'h0, err}, {31'h0, e[32]});
            end
        end else if (mon_en) begin
            if (rdata !== 32'h0 || err !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL idle_outputs actual=rdata 0x%08h err %0b required=0", rdata, err);
            end
        end
    end

    // One complete access: issue, check latency and busy window, return in IDLE.
    task automatic access(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        int  lat;
        int  busy_bad;
        bit  seen;
        exp_q.push_back({exp_err, exp_rd});
        @(negedge clk);
        we = w; size = sz; unsigned_ld = uns; addr = a; wdata = wd; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        lat = 1; seen = 1'b0; busy_bad = 0;
        while (!seen && lat <= 40) begin
            if (busy !== 1'b1) busy_bad++;
            if (ready === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk("latency", seen ? lat : 32'hFFFF_FFFF, WAIT_CYCLES + 1);
        chk("busy_window", busy_bad, 0);
        @(negedge clk);
        chk("busy_after", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        logic [11:0] pat;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_busy",  {31'h0, busy},  32'h0);
        chk("rst_err",   {31'h0, err},   32'h0);
        chk("rst_rdata", rdata, 32'h0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Word store/load
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte store into a zeroed word, signed and unsigned byte loads
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        access(1'b1, 2'b00, 1'b0, 32'h13, 32'hABCDEF80, 32'h0, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80000000, 1'b0);
        access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0);

        // Halfword and byte lanes within one word
        access(1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344, 32'h0, 1'b0);
        access(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF5566, 32'h0, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h55663344, 1'b0);
        access(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 32'h00005566, 1'b0);
        access(1'b1, 2'b00, 1'b0, 32'h15, 32'hF0, 32'h0, 1'b0);
        access(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 32'hFFFFF044, 1'b0);
        access(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 32'h0000F044, 1'b0);
        access(1'b0, 2'b00, 1'b1, 32'h14, 32'h0, 32'h00000044, 1'b0);
        access(1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 32'h00000055, 1'b0);
        access(1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 32'h5566F044, 1'b0);

        // Address wrap modulo DEPTH*4 bytes
        access(1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, 32'h0, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h12345678, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'hFFFFFF00, 32'h0, 32'h12345678, 1'b0);

        // req held high: one response every WAIT_CYCLES+2 cycles
        repeat (3) exp_q.push_back({1'b0, 32'h80000000});
        @(negedge clk);
        we = 1'b0; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h10; req = 1'b1;
        pat = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            pat[i-1] = ready;
        end
        req = 1'b0;
        chk("req_held_pattern", {20'h0, pat}, 32'h00000444);

        // Reset during WAIT aborts a store
        access(1'b1, 2'b10, 1'b0, 32'h20, 32'h01020304, 32'h0, 1'b0);
        @(negedge clk);
        we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'hFFFFFFFF; req = 1'b1;
        @(negedge clk);
        req = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy",  {31'h0, busy},  32'h0);
        chk("abort_ready", {31'h0, ready}, 32'h0);
        repeat (5) @(negedge clk);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h01020304, 1'b0);

        // Reset wins over a simultaneous request
        @(negedge clk);
        we = 1'b0; addr = 32'h20; req = 1'b1; reset = 1'b1;
        @(negedge clk);
        req = 1'b0; reset = 1'b0;
        chk("reset_over_req_busy", {31'h0, busy}, 32'h0);
        repeat (5) @(negedge clk);

        // Misaligned halfword store and load
`ifdef DMEM_MISALIGN_CHK_EN
        access(1'b1, 2'b01, 1'b0, 32'h21, 32'h00007777, 32'h0, 1'b1);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h01020304, 1'b0);
        access(1'b0, 2'b01, 1'b1, 32'h23, 32'h0, 32'h0, 1'b1);
        access(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1);
`else
        access(1'b1, 2'b01, 1'b0, 32'h21, 32'h00007777, 32'h0, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h01027777, 1'b0);
        access(1'b0, 2'b01, 1'b1, 32'h23, 32'h0, 32'h00000102, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h01027777, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_wait.md
DMEM_WAIT -- requirements
Module: dmem_wait

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words; power of two, >= 2.
REQ-002 Parameter WAIT_CYCLES, default 2, extra wait cycles per access; range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  access request; sampled only in IDLE.
REQ-006 we  input  1  1 = store, 0 = load; captured at accept.
REQ-007 size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 unsigned_ld  input  1  1 = zero-extend loads, 0 = sign-extend.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rdata  output  32  load result, valid only while ready = 1, else 0.
REQ-012 ready  output  1  one-cycle completion pulse.
REQ-013 busy  output  1  high from the cycle after accept through the ready cycle.
REQ-014 err  output  1  misalignment flag, valid with ready (see Configuration).

Function
REQ-015 FSM SHALL have states IDLE, WAIT, RESP; reset state IDLE.
REQ-016 IDLE with req = 1 SHALL capture we, size, unsigned_ld, addr, wdata and go to WAIT (WAIT_CYCLES > 0) or RESP (WAIT_CYCLES = 0).
REQ-017 WAIT SHALL count WAIT_CYCLES cycles, then enter RESP; RESP SHALL last exactly one cycle, then return to IDLE.
REQ-018 Request accepted at edge N SHALL produce ready = 1 during cycle N+1+WAIT_CYCLES.
REQ-019 req outside IDLE SHALL be ignored; no queueing; minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-020 Word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits ignored (wrap modulo DEPTH*4 bytes).
REQ-021 Store SHALL commit at the ready edge, writing only lanes selected by size and addr[1:0]; other bytes unchanged.
REQ-022 Load SHALL select lane by addr[1:0], extend per unsigned_ld, drive rdata only in RESP.
REQ-023 Store cycle SHALL drive rdata = 0.
REQ-024 Memory contents SHALL NOT be initialised or cleared by reset; contents are preserved across reset.

Reset
REQ-025 reset = 1 SHALL force IDLE, clear wait counter, drive ready = 0, busy = 0, err = 0, rdata = 0 on the next edge.
REQ-026 reset asserted during WAIT or RESP SHALL abort the access; no store committed, no ready pulse.
REQ-027 reset overrides req in the same cycle.

Configuration
REQ-028 Macro DMEM_MISALIGN_CHK_EN defined: halfword with addr[0] = 1 or word with addr[1:0] != 0 SHALL complete with normal latency, ready = 1, err = 1, rdata = 0, no store.
REQ-029 Macro undefined: err SHALL be tied 0; misaligned accesses SHALL use address with low bits forced to alignment of size.

Structure
REQ-030 Package dmem_pkg SHALL hold size encoding enum (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state enum.
REQ-031 Combinational sub-module dmem_lane_align SHALL produce byte enables, shifted store data and extended load data from size, addr[1:0], unsigned_ld.
REQ-032 Storage SHALL be a single array of DEPTH 32-bit words with per-byte write enables.

Verification
REQ-033 WAIT_CYCLES = 2: word store 0xDEADBEEF to 0x10 at edge 0 -> ready at cycle 3, busy cycles 1-3; word load 0x10 -> rdata 0xDEADBEEF.
REQ-034 Byte store 0x80 to 0x13 over 0x00000000 -> word 0x80000000; signed byte load 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-035 DEPTH = 64: store 0x12345678 to 0x100 -> load 0x000 returns 0x12345678 (wrap).
REQ-036 req held high continuously -> accepts only in IDLE, one ready every WAIT_CYCLES+2 cycles.
REQ-037 reset asserted in WAIT of a store to 0x20 -> no ready, word 0x20 unchanged, busy 0 next cycle.
REQ-038 With DMEM_MISALIGN_CHK_EN: halfword store to 0x21 -> ready with err = 1, memory unchanged; without: halfword store to 0x20.
